mips_data_mem_arbiter: RTL and testbench
========================================

# mips_data_mem_arbiter

Arbitrates the single-port `mips_cpu_data_memory` between the `mips_cpu_harvard` data port and a DMA/loader port used by benches and the boot loader. It sits between the CPU's data-side signals and the memory instance. The CPU keeps priority outside bursts. During a DMA burst the CPU is stalled through its `clk_enable`, with a bounded-run yield so CPU loads/stores cannot starve. Instruction fetch is unaffected because it uses the separate Harvard port.

## Interface
- `MAX_DMA_RUN`, default 4: maximum consecutive DMA beats before a one-cycle yield to a waiting CPU access (legal range 1–255).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cpu_read`, `cpu_write`  in  1  CPU data request, mutually exclusive.
- `cpu_address`  in  32  CPU byte address (word aligned).
- `cpu_writedata`  in  32  CPU store data.
- `cpu_readdata`  out  32  equals `mem_readdata`.
- `cpu_clk_enable`  out  1  drives the CPU `clk_enable`; 0 stalls the CPU.
- `dma_req`  in  1  level start request, sampled in IDLE only.
- `dma_write`  in  1  burst direction, latched at start (1 = write memory).
- `dma_address`  in  32  burst start address, latched at start.
- `dma_len`  in  8  beat count, latched at start; 0 means no beats.
- `dma_writedata`  in  32  write data, consumed on each `dma_beat` cycle.
- `dma_readdata`  out  32  equals `mem_readdata`; valid when `dma_beat` = 1 and the burst is a read.
- `dma_beat`  out  1  a DMA beat occupies memory this cycle.
- `dma_busy`  out  1  burst in progress (DMA or YIELD state).
- `dma_done`  out  1  one-cycle pulse after the final beat.
- `mem_address`, `mem_writedata`  out  32  to memory.
- `mem_read`, `mem_write`  out  1  to memory.
- `mem_readdata`  in  32  from memory; combinational read; writes commit on the rising edge.

## Operation
- FSM states: IDLE, DMA, YIELD.
- Registers:
  - `cur_addr` (32)
  - `beats_left` (8)
  - `run_cnt` (8)
  - latched direction `dir`
- **IDLE**
  - The memory mux selects the CPU; `cpu_clk_enable` = 1.
  - If `dma_req` = 1 and `dma_len` ≠ 0, latch `cur_addr` = `dma_address`, `beats_left` = `dma_len`, `dir` = `dma_write`, and `run_cnt` = 0. Go to DMA.
  - If `dma_req` = 1 and `dma_len` = 0, pulse `dma_done` next cycle and stay in IDLE.
  - A CPU access in the same cycle is served normally.
- **DMA**
  - The mux selects DMA: `mem_address` = `cur_addr`, `mem_write` = `dir`, `mem_read` = !`dir`, `mem_writedata` = `dma_writedata`, `dma_beat` = 1.
  - `cpu_clk_enable` = !(`cpu_read` | `cpu_write`): the CPU free-runs unless it needs memory.
  - On each beat: `cur_addr` += 4 (wraps modulo 2^32), `beats_left` −= 1, `run_cnt` += 1.
  - If `beats_left` = 1, this is the final beat: go to IDLE and register `dma_done` = 1 for the next cycle.
  - Otherwise, if `run_cnt` + 1 = `MAX_DMA_RUN` and the CPU is requesting in that cycle, go to YIELD.
  - Otherwise stay in DMA.
  - If `run_cnt` reaches `MAX_DMA_RUN` with no CPU request, `run_cnt` saturates and the yield is taken on the first later beat where the CPU requests.
- **YIELD**
  - The mux selects the CPU; `cpu_clk_enable` = 1; `dma_beat` = 0.
  - `run_cnt` = 0; return to DMA.
  - If the CPU withdrew its request, the cycle idles the memory (`mem_read` = `mem_write` = 0).
- `dma_req` is ignored while `dma_busy` = 1. A new request is accepted in IDLE on the cycle after `dma_done`.
- When the CPU mux is selected, `mem_read`/`mem_write` mirror `cpu_read`/`cpu_write`. No memory strobe is ever driven by both sides in one cycle.

## Timing
- Reset (`reset` = 0 at a rising edge):
  - State goes to IDLE.
  - `cur_addr`, `beats_left` and `run_cnt` = 0; `dma_done` = 0.
  - `dma_busy` = 0, `dma_beat` = 0, `cpu_clk_enable` = 1.
  - Memory strobes follow the CPU inputs.
  - Reset mid-burst aborts the burst: no `dma_done` pulse, and beats not yet performed are never written.
- Start latency: `dma_req` sampled high in IDLE at edge N gives the first beat in cycle N+1.
- A burst of L beats with no CPU contention:
  - occupies memory for L consecutive cycles;
  - `dma_busy` = 1 for those L cycles;
  - `dma_done` is high in the cycle after the last beat.
- With continuous CPU contention, L beats take L + floor((L−1)/`MAX_DMA_RUN`) cycles. The CPU is stalled in every DMA-state cycle.
- The CPU's stalled request is re-presented unchanged, and completes in the YIELD cycle or the first IDLE cycle.
- All outputs other than `dma_done` are combinational from state and inputs. `dma_done` is registered.

## Test plan
- **Reset.** Hold `reset` = 0 for 2 cycles mid-burst (`dma_len` = 8, after 3 beats) → `dma_busy` = 0, `cpu_clk_enable` = 1, no `dma_done`, addresses +12 onward untouched.
- **Uncontended write.** DMA write, `dma_address` = 0x100, `dma_len` = 4, data 1..4, CPU idle → `mem_write` at 0x100/0x104/0x108/0x10C in 4 consecutive cycles, `dma_done` 1 cycle later; CPU `lw` afterwards returns 1, 2, 3, 4.
- **Contended read with yield.** `MAX_DMA_RUN` = 4, DMA read of 10 beats, CPU holds `cpu_read` @0x200 throughout → `cpu_clk_enable` low 4 cycles, high 1 (YIELD), low 4, high 1, low 2; total 12 cycles; `dma_readdata` correct on every beat.
- **Zero length.** `dma_len` = 0 in IDLE → no beat, `dma_busy` stays 0, `dma_done` pulses the next cycle.
- **Same-cycle request and wrap-around.** CPU `sw` and `dma_req` in the same IDLE cycle → the store completes that cycle and the first DMA beat follows. A separate burst with `dma_address` = 0xFFFFFFFC and `dma_len` = 2 touches 0xFFFFFFFC and then 0x00000000.
- **CPU program under DMA.** A CPU with no memory ops during a burst (e.g. a branch test program) → `cpu_clk_enable` stays 1 and the program's `register_v0` result is unchanged versus a run without DMA.

Source files
------------

// File: rtl/mips_data_mem_arbiter.sv
// Data-memory arbiter between the mips_cpu_harvard data port and a DMA/loader
// port. The CPU owns memory outside bursts; during a burst the CPU is stalled
// through its clk_enable, and a bounded DMA run length guarantees a yield
// cycle to a waiting CPU load/store.
module mips_data_mem_arbiter #(
  parameter int unsigned MAX_DMA_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_clk_enable,
  input  logic        dma_req,
  input  logic        dma_write,
  input  logic [31:0] dma_address,
  input  logic [7:0]  dma_len,
  input  logic [31:0] dma_writedata,
  output logic [31:0] dma_readdata,
  output logic        dma_beat,
  output logic        dma_busy,
  output logic        dma_done,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DMA   = 2'd1,
    ST_YIELD = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX_RUN = 8'(MAX_DMA_RUN);

  state_t      r_state;
  logic [31:0] r_cur_addr;
  logic [7:0]  r_beats_left;
  logic [7:0]  r_run_cnt;
  logic        r_dir;
  logic        r_dma_done;

  state_t      w_state_nxt;
  logic [31:0] w_cur_addr_nxt;
  logic [7:0]  w_beats_left_nxt;
  logic [7:0]  w_run_cnt_nxt;
  logic        w_dir_nxt;
  logic        w_dma_done_nxt;

  logic        w_cpu_req;
  logic        w_run_hit;
  logic [7:0]  w_run_inc;
  state_t      w_out_state;

  assign w_cpu_req = cpu_read | cpu_write;
  // Run limit reached once this beat would make the run MAX_DMA_RUN long;
  // run_cnt saturates at the limit so a late CPU request still yields.
  assign w_run_hit = (r_run_cnt >= (LP_MAX_RUN - 8'd1));
  assign w_run_inc = (r_run_cnt >= LP_MAX_RUN) ? LP_MAX_RUN : (r_run_cnt + 8'd1);

  // While reset is held the outputs behave as IDLE, so a beat that was in
  // flight when reset arrived is never committed to memory.
  assign w_out_state = reset ? r_state : ST_IDLE;

  // Next-state and burst bookkeeping.
  always_comb begin
    w_state_nxt      = r_state;
    w_cur_addr_nxt   = r_cur_addr;
    w_beats_left_nxt = r_beats_left;
    w_run_cnt_nxt    = r_run_cnt;
    w_dir_nxt        = r_dir;
    w_dma_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dma_req) begin
          if (dma_len != 8'd0) begin
            w_cur_addr_nxt   = dma_address;
            w_beats_left_nxt = dma_len;
            w_dir_nxt        = dma_write;
            w_run_cnt_nxt    = 8'd0;
            w_state_nxt      = ST_DMA;
          end else begin
            w_dma_done_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DMA: begin
        w_cur_addr_nxt   = r_cur_addr + 32'd4;
        w_beats_left_nxt = r_beats_left - 8'd1;
        w_run_cnt_nxt    = w_run_inc;
        if (r_beats_left == 8'd1) begin
          w_state_nxt    = ST_IDLE;
          w_dma_done_nxt = 1'b1;
        end else if (w_run_hit && w_cpu_req) begin
          w_state_nxt    = ST_YIELD;
        end else begin
          w_state_nxt    = ST_DMA;
        end
      end
      ST_YIELD: begin
        w_run_cnt_nxt = 8'd0;
        w_state_nxt   = ST_DMA;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and burst registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cur_addr   <= 32'd0;
      r_beats_left <= 8'd0;
      r_run_cnt    <= 8'd0;
      r_dir        <= 1'b0;
      r_dma_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_addr   <= w_cur_addr_nxt;
      r_beats_left <= w_beats_left_nxt;
      r_run_cnt    <= w_run_cnt_nxt;
      r_dir        <= w_dir_nxt;
      r_dma_done   <= w_dma_done_nxt;
    end
  end

  // Memory mux and CPU stall decode; only one side ever drives the strobes.
  always_comb begin
    mem_address    = cpu_address;
    mem_writedata  = cpu_writedata;
    mem_read       = cpu_read;
    mem_write      = cpu_write;
    cpu_clk_enable = 1'b1;
    dma_beat       = 1'b0;
    dma_busy       = 1'b0;
    case (w_out_state)
      ST_IDLE: begin
        dma_busy = 1'b0;
      end
      ST_DMA: begin
        mem_address    = r_cur_addr;
        mem_writedata  = dma_writedata;
        mem_read       = ~r_dir;
        mem_write      = r_dir;
        cpu_clk_enable = ~w_cpu_req;
        dma_beat       = 1'b1;
        dma_busy       = 1'b1;
      end
      ST_YIELD: begin
        dma_busy = 1'b1;
      end
      default: begin
        dma_busy = 1'b0;
      end
    endcase
  end

  assign cpu_readdata = mem_readdata;
  assign dma_readdata = mem_readdata;
  assign dma_done     = r_dma_done;

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// Directed bench for mips_data_mem_arbiter with a behavioural single-port
// memory (combinational read, write on the rising edge).
module tb_mips_data_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_address, cpu_writedata, cpu_readdata;
  logic        cpu_clk_enable;
  logic        dma_req, dma_write;
  logic [31:0] dma_address;
  logic [7:0]  dma_len;
  logic [31:0] dma_writedata, dma_readdata;
  logic        dma_beat, dma_busy, dma_done;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write;

  logic [31:0] tb_mem [0:255];
  int tests;
  int fails;

  mips_data_mem_arbiter #(.MAX_DMA_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
    .cpu_readdata(cpu_readdata), .cpu_clk_enable(cpu_clk_enable),
    .dma_req(dma_req), .dma_write(dma_write), .dma_address(dma_address),
    .dma_len(dma_len), .dma_writedata(dma_writedata), .dma_readdata(dma_readdata),
    .dma_beat(dma_beat), .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_readdata = tb_mem[mem_address[9:2]];

  // Memory write port.
  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_address[9:2]] <= mem_writedata;
  end

  task automatic test_reset;
    reset = 1'b0; cpu_read = 1'b1; cpu_address = 32'h0000_0010;
    @(negedge clk); @(negedge clk); #1;
    tests++; if (dma_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", dma_busy); end
    tests++; if (dma_beat !== 1'b0) begin fails++; $display("FAIL rst_beat: got %b want 0", dma_beat); end
    tests++; if (dma_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", dma_done); end
    tests++; if (cpu_clk_enable !== 1'b1) begin fails++; $display("FAIL rst_clken: got %b want 1", cpu_clk_enable); end
    tests++; if (mem_read !== 1'b1 || mem_address !== 32'h10) begin fails++; $display("FAIL rst_mux: got rd=%b addr=%h want 1/00000010", mem_read, mem_address); end
    cpu_read = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_uncontended_write;
    @(negedge clk);
    dma_req = 1'b1; dma_write = 1'b1; dma_address = 32'h100; dma_len = 8'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dma_req = 1'b0; dma_writedata = 32'(i + 1); #1;
      tests++; if (dma_beat !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0) begin fails++; $display("FAIL wr_strobe beat %0d: got beat=%b wr=%b rd=%b want 1/1/0", i, dma_beat, mem_write, mem_read); end
      tests++; if (mem_address !== 32'h100 + 32'(4 * i)) begin fails++; $display("FAIL wr_addr beat %0d: got %h want %h", i, mem_address, 32'h100 + 32'(4 * i)); end
      tests++; if (dma_busy !== 1'b1 || cpu_clk_enable !== 1'b1 || dma_done !== 1'b0) begin fails++; $display("FAIL wr_ctrl beat %0d: got busy=%b en=%b done=%b want 1/1/0", i, dma_busy, cpu_clk_enable, dma_done); end
    end
    @(negedge clk); #1;
    tests++; if (dma_done !== 1'b1 || dma_busy !== 1'b0 || dma_beat !== 1'b0) begin fails++; $display("FAIL wr_done: got done=%b busy=%b beat=%b want 1/0/0", dma_done, dma_busy, dma_beat); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 32'h100 + 32'(4 * i); #1;
      tests++; if (cpu_readdata !== 32'(i + 1)) begin fails++; $display("FAIL wr_lw %0d: got %h want %h", i, cpu_readdata, 32'(i + 1)); end
    end
    @(negedge clk); cpu_read = 1'b0;
    tests++; if (dma_done !== 1'b0) begin fails++; $display("FAIL wr_done_once: got %b want 0", dma_done); end
  endtask

  task automatic test_contended_read;
    logic [11:0] exp_en;
    int k;
    exp_en = 12'b0010_0001_0000;
    k = 0;
    tb_mem[8'h80] = 32'h0000_C0DE;
    for (int i = 0; i < 10; i++) tb_mem[8'h10 + 8'(i)] = 32'h5000 + 32'(i);
    @(negedge clk);
    dma_req = 1'b1; dma_write = 1'b0; dma_address = 32'h40; dma_len = 8'd10;
    cpu_read = 1'b1; cpu_address = 32'h200;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      dma_req = 1'b0; #1;
      tests++; if (cpu_clk_enable !== exp_en[c]) begin fails++; $display("FAIL cr_clken cyc %0d: got %b want %b", c, cpu_clk_enable, exp_en[c]); end
      tests++; if (dma_busy !== 1'b1) begin fails++; $display("FAIL cr_busy cyc %0d: got %b want 1", c, dma_busy); end
      if (exp_en[c]) begin
        tests++; if (dma_beat !== 1'b0 || mem_address !== 32'h200 || cpu_readdata !== 32'hC0DE) begin fails++; $display("FAIL cr_yield cyc %0d: got beat=%b addr=%h data=%h want 0/200/c0de", c, dma_beat, mem_address, cpu_readdata); end
      end else begin
        tests++; if (dma_beat !== 1'b1 || mem_address !== 32'h40 + 32'(4 * k) || mem_read !== 1'b1) begin fails++; $display("FAIL cr_beat cyc %0d: got beat=%b addr=%h rd=%b want 1/%h/1", c, dma_beat, mem_address, mem_read, 32'h40 + 32'(4 * k)); end
        tests++; if (dma_readdata !== 32'h5000 + 32'(k)) begin fails++; $display("FAIL cr_data beat %0d: got %h want %h", k, dma_readdata, 32'h5000 + 32'(k)); end
        k++;
      end
    end
    @(negedge clk); #1;
    tests++; if (dma_done !== 1'b1 || dma_busy !== 1'b0 || cpu_clk_enable !== 1'b1) begin fails++; $display("FAIL cr_done: got done=%b busy=%b en=%b want 1/0/1", dma_done, dma_busy, cpu_clk_enable); end
    tests++; if (cpu_readdata !== 32'hC0DE) begin fails++; $display("FAIL cr_cpu_idle: got %h want c0de", cpu_readdata); end
    cpu_read = 1'b0;
  endtask

  task automatic test_zero_length;
    @(negedge clk);
    dma_req = 1'b1; dma_len = 8'd0; dma_write = 1'b1; dma_address = 32'h0; #1;
    tests++; if (dma_beat !== 1'b0 || dma_busy !== 1'b0) begin fails++; $display("FAIL zl_idle: got beat=%b busy=%b want 0/0", dma_beat, dma_busy); end
    @(negedge clk);
    dma_req = 1'b0; #1;
    tests++; if (dma_done !== 1'b1 || dma_busy !== 1'b0 || dma_beat !== 1'b0) begin fails++; $display("FAIL zl_done: got done=%b busy=%b beat=%b want 1/0/0", dma_done, dma_busy, dma_beat); end
    @(negedge clk); #1;
    tests++; if (dma_done !== 1'b0) begin fails++; $display("FAIL zl_pulse: got %b want 0", dma_done); end
  endtask

  task automatic test_same_cycle_and_wrap;
    @(negedge clk);
    cpu_write = 1'b1; cpu_address = 32'hA0; cpu_writedata = 32'h77;
    dma_req = 1'b1; dma_write = 1'b1; dma_address = 32'hB0; dma_len = 8'd1; dma_writedata = 32'h99; #1;
    tests++; if (mem_write !== 1'b1 || mem_address !== 32'hA0 || mem_writedata !== 32'h77 || dma_beat !== 1'b0) begin fails++; $display("FAIL sc_cpu: got wr=%b addr=%h data=%h beat=%b want 1/a0/77/0", mem_write, mem_address, mem_writedata, dma_beat); end
    @(negedge clk);
    cpu_write = 1'b0; dma_req = 1'b0; #1;
    tests++; if (dma_beat !== 1'b1 || mem_address !== 32'hB0 || mem_writedata !== 32'h99) begin fails++; $display("FAIL sc_beat: got beat=%b addr=%h data=%h want 1/b0/99", dma_beat, mem_address, mem_writedata); end
    @(negedge clk); #1;
    tests++; if (dma_done !== 1'b1) begin fails++; $display("FAIL sc_done: got %b want 1", dma_done); end
    tests++; if (tb_mem[8'h28] !== 32'h77 || tb_mem[8'h2C] !== 32'h99) begin fails++; $display("FAIL sc_mem: got %h/%h want 77/99", tb_mem[8'h28], tb_mem[8'h2C]); end
    dma_req = 1'b1; dma_address = 32'hFFFF_FFFC; dma_len = 8'd2;
    @(negedge clk);
    dma_req = 1'b0; dma_writedata = 32'h11; #1;
    tests++; if (mem_address !== 32'hFFFF_FFFC || dma_beat !== 1'b1) begin fails++; $display("FAIL wrap_a0: got addr=%h beat=%b want fffffffc/1", mem_address, dma_beat); end
    @(negedge clk);
    dma_writedata = 32'h22; #1;
    tests++; if (mem_address !== 32'h0 || dma_beat !== 1'b1) begin fails++; $display("FAIL wrap_a1: got addr=%h beat=%b want 00000000/1", mem_address, dma_beat); end
    @(negedge clk); #1;
    tests++; if (dma_done !== 1'b1 || tb_mem[8'hFF] !== 32'h11 || tb_mem[8'h00] !== 32'h22) begin fails++; $display("FAIL wrap_done: got done=%b mem=%h/%h want 1/11/22", dma_done, tb_mem[8'hFF], tb_mem[8'h00]); end
  endtask

  task automatic test_cpu_program_and_saturation;
    int stalls;
    stalls = 0;
    @(negedge clk);
    dma_req = 1'b1; dma_write = 1'b0; dma_address = 32'h40; dma_len = 8'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dma_req = 1'b0; #1;
      if (cpu_clk_enable !== 1'b1) stalls++;
      tests++; if (dma_beat !== 1'b1 || mem_address !== 32'h40 + 32'(4 * i)) begin fails++; $display("FAIL sat_beat %0d: got beat=%b addr=%h want 1/%h", i, dma_beat, mem_address, 32'h40 + 32'(4 * i)); end
    end
    tests++; if (stalls !== 0) begin fails++; $display("FAIL prog_stalls: got %0d want 0", stalls); end
    @(negedge clk);
    cpu_read = 1'b1; cpu_address = 32'h200; #1;
    tests++; if (cpu_clk_enable !== 1'b0 || dma_beat !== 1'b1 || mem_address !== 32'h54) begin fails++; $display("FAIL sat_late_req: got en=%b beat=%b addr=%h want 0/1/54", cpu_clk_enable, dma_beat, mem_address); end
    @(negedge clk); #1;
    tests++; if (cpu_clk_enable !== 1'b1 || dma_beat !== 1'b0 || dma_busy !== 1'b1 || mem_address !== 32'h200) begin fails++; $display("FAIL sat_yield: got en=%b beat=%b busy=%b addr=%h want 1/0/1/200", cpu_clk_enable, dma_beat, dma_busy, mem_address); end
    @(negedge clk);
    cpu_read = 1'b0; #1;
    tests++; if (dma_beat !== 1'b1 || mem_address !== 32'h58) begin fails++; $display("FAIL sat_resume: got beat=%b addr=%h want 1/58", dma_beat, mem_address); end
    @(negedge clk); #1;
    tests++; if (dma_beat !== 1'b1 || mem_address !== 32'h5C || dma_readdata !== 32'h5007) begin fails++; $display("FAIL sat_last: got beat=%b addr=%h data=%h want 1/5c/5007", dma_beat, mem_address, dma_readdata); end
    @(negedge clk); #1;
    tests++; if (dma_done !== 1'b1 || dma_busy !== 1'b0) begin fails++; $display("FAIL sat_done: got done=%b busy=%b want 1/0", dma_done, dma_busy); end
  endtask

  task automatic test_reset_mid_burst;
    for (int i = 0; i < 8; i++) tb_mem[8'hC0 + 8'(i)] = 32'hDEAD_0000 + 32'(i);
    @(negedge clk);
    dma_req = 1'b1; dma_write = 1'b1; dma_address = 32'h300; dma_len = 8'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dma_req = 1'b0; dma_writedata = 32'hA1 + 32'(i);
    end
    @(negedge clk);
    reset = 1'b0; dma_writedata = 32'hBAD; #1;
    tests++; if (dma_busy !== 1'b0 || cpu_clk_enable !== 1'b1 || mem_write !== 1'b0) begin fails++; $display("FAIL mrst_out: got busy=%b en=%b wr=%b want 0/1/0", dma_busy, cpu_clk_enable, mem_write); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; #1;
    tests++; if (dma_busy !== 1'b0 || dma_done !== 1'b0 || dma_beat !== 1'b0) begin fails++; $display("FAIL mrst_idle: got busy=%b done=%b beat=%b want 0/0/0", dma_busy, dma_done, dma_beat); end
    @(negedge clk); #1;
    tests++; if (dma_done !== 1'b0 || dma_busy !== 1'b0) begin fails++; $display("FAIL mrst_nodone: got done=%b busy=%b want 0/0", dma_done, dma_busy); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (tb_mem[8'hC0 + 8'(i)] !== ((i < 3) ? (32'hA1 + 32'(i)) : (32'hDEAD_0000 + 32'(i)))) begin
        fails++; $display("FAIL mrst_mem %0d: got %h want %h", i, tb_mem[8'hC0 + 8'(i)], (i < 3) ? (32'hA1 + 32'(i)) : (32'hDEAD_0000 + 32'(i)));
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'd0;
    reset = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_address = 32'd0; cpu_writedata = 32'd0;
    dma_req = 1'b0; dma_write = 1'b0; dma_address = 32'd0; dma_len = 8'd0; dma_writedata = 32'd0;
    test_reset;
    test_uncontended_write;
    test_contended_read;
    test_zero_length;
    test_same_cycle_and_wrap;
    test_cpu_program_and_saturation;
    test_reset_mid_burst;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
